// File: rtl/handshake_pkg.sv
// Shared definitions for the handshake unit family: sequencing mode
// encodings and an index-width helper.
package handshake_pkg;

    localparam int MODE_HOLD  = 0;
    localparam int MODE_CYCLE = 1;
    localparam int MODE_ONCE  = 2;

    // Index width for an n-entry table; a single entry still needs one bit.
    function automatic int idx_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/handshake_oehb_reg.sv
// One-slot registered elastic buffer: registers both data and valid, so the
// consumer sees no combinational path from the producer.
module handshake_oehb_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  srst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  full_r;
    logic [DATA_WIDTH-1:0] data_r;

    assign in_ready  = !full_r || out_ready;
    assign out_valid = full_r;
    assign out_data  = data_r;

    // Slot state: load on an input transfer, drain on an output-only transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 1'b0;
            data_r <= '0;
        end else if (srst) begin
            full_r <= 1'b0;
            data_r <= '0;
        end else if (in_valid && in_ready) begin
            full_r <= 1'b1;
            data_r <= in_data;
        end else if (out_ready) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
            data_r <= data_r;
        end
    end

endmodule

// File: rtl/handshake_constant_seq.sv
// Elastic constant-sequence source: each accepted control token emits the next
// entry of a constant table through a one-slot registered output buffer.
module handshake_constant_seq
    import handshake_pkg::*;
#(
    parameter int                            DATA_WIDTH = 32,
    parameter int                            DEPTH      = 4,
    parameter logic [DEPTH*DATA_WIDTH-1:0]   INIT       = '0,
    parameter int                            MODE       = MODE_HOLD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    input  logic                  seq_restart,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic                  seq_done
);

    localparam int               IDX_W    = idx_width(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [IDX_W-1:0]      idx_r;
    logic [IDX_W-1:0]      idx_nxt_s;
    logic                  done_r;
    logic                  done_nxt_s;
    logic                  ctrl_xfer_s;
    logic [DATA_WIDTH-1:0] table_s;

    assign ctrl_xfer_s = ctrl_valid && ctrl_ready;
    assign seq_done    = done_r;

    // Table lookup as a one-hot OR so an out-of-range index reads as zero.
    always_comb begin
        table_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            table_s = table_s |
                      ((idx_r == IDX_W'(k)) ? INIT[k*DATA_WIDTH +: DATA_WIDTH]
                                            : {DATA_WIDTH{1'b0}});
        end
    end

    // Next index/done: restart overrides the increment of a coincident transfer.
    always_comb begin
        idx_nxt_s  = idx_r;
        done_nxt_s = done_r;
        if (seq_restart) begin
            idx_nxt_s  = '0;
            done_nxt_s = 1'b0;
        end else if (ctrl_xfer_s) begin
            case (MODE)
                MODE_HOLD: begin
                    idx_nxt_s = '0;
                end
                MODE_CYCLE: begin
                    idx_nxt_s = (idx_r == LAST_IDX) ? '0 : idx_r + IDX_W'(1);
                end
                MODE_ONCE: begin
                    idx_nxt_s  = (idx_r == LAST_IDX) ? LAST_IDX : idx_r + IDX_W'(1);
                    done_nxt_s = done_r || (idx_r == LAST_IDX);
                end
                default: begin
                    idx_nxt_s  = '0;
                    done_nxt_s = 1'b0;
                end
            endcase
        end else begin
            idx_nxt_s  = idx_r;
            done_nxt_s = done_r;
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_r  <= '0;
            done_r <= 1'b0;
        end else begin
            idx_r  <= idx_nxt_s;
            done_r <= done_nxt_s;
        end
    end

    handshake_oehb_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_oehb (
        .clk       (clk),
        .rst_n     (rst),
        .srst      (1'b0),
        .in_valid  (ctrl_valid),
        .in_ready  (ctrl_ready),
        .in_data   (table_s),
        .out_valid (outs_valid),
        .out_ready (outs_ready),
        .out_data  (outs)
    );

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Bench for handshake_constant_seq: one instance per mode sharing stimulus,
// each checked every cycle against a token-count model plus literal pins.
module tb_handshake_constant_seq;

    localparam int DW = 8;
    localparam int DP = 3;
    localparam logic [DP*DW-1:0] TBL_INIT = 24'h332211;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ctrl_valid = 1'b0;
    logic seq_restart = 1'b0;
    logic outs_ready = 1'b0;

    logic [2:0]    ready_v;
    logic [2:0]    valid_v;
    logic [2:0]    done_v;
    logic [DW-1:0] outs_a [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        handshake_constant_seq #(
            .DATA_WIDTH (DW),
            .DEPTH      (DP),
            .INIT       (TBL_INIT),
            .MODE       (g)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .ctrl_valid  (ctrl_valid),
            .ctrl_ready  (ready_v[g]),
            .seq_restart (seq_restart),
            .outs        (outs_a[g]),
            .outs_valid  (valid_v[g]),
            .outs_ready  (outs_ready),
            .seq_done    (done_v[g])
        );
    end

    // Model: tokens issued since restart per mode, plus the output slot.
    int            n_tok [3];
    bit            m_valid [3];
    logic [DW-1:0] m_data [3];
    logic [DW-1:0] tbl [3] = '{8'h11, 8'h22, 8'h33};

    int n_cmp = 0;
    int n_err = 0;

    int lit_cyc [7] = '{'h11, 'h22, 'h33, 'h11, 'h22, 'h33, 'h11};
    int lit_once [7] = '{'h11, 'h22, 'h33, 'h33, 'h33, 'h33, 'h33};

    function automatic int entry_of(input int m, input int n);
        if (m == 0) return 0;
        if (m == 1) return n % DP;
        return (n < DP - 1) ? n : DP - 1;
    endfunction

    task automatic check(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s mode=%0d actual=%0h required=%0h at %0t", nm, m, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 3; m++) begin
            n_tok[m]   = 0;
            m_valid[m] = 1'b0;
            m_data[m]  = '0;
        end
    endtask

    task automatic model_update(input bit cv, input bit rs, input bit ordy);
        for (int m = 0; m < 3; m++) begin
            bit rdy;
            rdy = !m_valid[m] || ordy;
            if (cv && rdy) begin
                m_data[m]  = tbl[entry_of(m, n_tok[m])];
                m_valid[m] = 1'b1;
                n_tok[m]++;
            end else if (ordy) begin
                m_valid[m] = 1'b0;
            end
            if (rs) n_tok[m] = 0;
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < 3; m++) begin
            check("outs_valid", m, 32'(valid_v[m]), 32'(m_valid[m]));
            check("outs", m, 32'(outs_a[m]), 32'(m_data[m]));
            check("seq_done", m, 32'(done_v[m]), 32'((m == 2) && (n_tok[m] >= DP)));
        end
    endtask

    // Drive at negedge, check ready combinationally, advance model, compare next negedge.
    task automatic step(input bit cv, input bit rs, input bit ordy);
        ctrl_valid  = cv;
        seq_restart = rs;
        outs_ready  = ordy;
        #1;
        for (int m = 0; m < 3; m++)
            check("ctrl_ready", m, 32'(ready_v[m]), 32'(!m_valid[m] || ordy));
        if (rst) model_update(cv, rs, ordy);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        model_reset();
        ctrl_valid = 1'b1;
        outs_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        compare_all();
        for (int m = 0; m < 3; m++) begin
            check("rst_valid_lit", m, 32'(valid_v[m]), 32'd0);
            check("rst_outs_lit", m, 32'(outs_a[m]), 32'd0);
        end

        // Release reset: first token one cycle later.
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        for (int m = 0; m < 3; m++) begin
            check("first_valid_lit", m, 32'(valid_v[m]), 32'd1);
            check("first_outs_lit", m, 32'(outs_a[m]), 32'h11);
        end

        // Streaming from a fresh index.
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, 1'b1);
            check("hold_lit", 0, 32'(outs_a[0]), 32'h11);
            check("cycle_lit", 1, 32'(outs_a[1]), 32'(lit_cyc[i]));
            check("once_lit", 2, 32'(outs_a[2]), 32'(lit_once[i]));
            check("once_done_lit", 2, 32'(done_v[2]), 32'(i >= 2));
            check("hold_done_lit", 0, 32'(done_v[0]), 32'd0);
            check("cycle_ready_lit", 1, 32'(ready_v[1]), 32'd1);
        end

        // Backpressure: token held, ready low while full, no skip afterwards.
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check("bp_outs_lit", 1, 32'(outs_a[1]), 32'h11);
            check("bp_ready_lit", 1, 32'(ready_v[1]), 32'd0);
        end
        step(1'b1, 1'b0, 1'b1);
        check("bp_next_lit", 1, 32'(outs_a[1]), 32'h22);

        // Restart coinciding with the transfer of entry 1.
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("rs_tok_lit", 1, 32'(outs_a[1]), 32'h22);
        step(1'b1, 1'b0, 1'b1);
        check("rs_after_lit", 1, 32'(outs_a[1]), 32'h11);

        // Restart clears seq_done in ONCE mode.
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        check("done_set_lit", 2, 32'(done_v[2]), 32'd1);
        step(1'b1, 1'b1, 1'b1);
        check("done_clr_lit", 2, 32'(done_v[2]), 32'd0);
        check("done_clr_outs_lit", 2, 32'(outs_a[2]), 32'h33);
        step(1'b1, 1'b0, 1'b1);
        check("once_restart_lit", 2, 32'(outs_a[2]), 32'h11);

        // Asynchronous reset while a token is buffered.
        step(1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        for (int m = 0; m < 3; m++)
            check("async_rst_valid_lit", m, 32'(valid_v[m]), 32'd0);
        model_reset();
        @(negedge clk);
        compare_all();
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        for (int m = 0; m < 3; m++)
            check("post_rst_outs_lit", m, 32'(outs_a[m]), 32'h11);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 3) != 0),
                 bit'($urandom_range(0, 19) == 0),
                 bit'($urandom_range(0, 4) < 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
